// File: rtl/byte_striping_param.sv
// rtl/byte_striping_param.sv - round-robin byte striper with lane-enable mask, flush and ready/valid
module byte_striping_param #(
    parameter int                LANES = 4,
    parameter int                WIDTH = 8,
    parameter logic [WIDTH-1:0]  PAD   = WIDTH'(8'hBC),
    localparam int               PTR_W = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                     clk,
    input  logic                     reset_L,
    input  logic [WIDTH-1:0]         byteStripingIN,
    input  logic                     inVLD,
    output logic                     inRDY,
    input  logic [LANES-1:0]         laneEN,
    input  logic                     flush,
    output logic [LANES*WIDTH-1:0]   stripedOUT,
    output logic [LANES-1:0]         laneVLD,
    output logic                     byteStripingVLD,
    input  logic                     outRDY,
    output logic [PTR_W-1:0]         lanePtr
);

    logic [LANES*WIDTH-1:0] acc_q, acc_d, acc_new;
    logic [LANES-1:0]       fill_q, fill_d, fill_new;
    logic [LANES-1:0]       en_q, en_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [LANES*WIDTH-1:0] out_q, out_d;
    logic [LANES-1:0]       lvld_q, lvld_d;
    logic                   vld_q, vld_d;

    logic                   empty, slot_free, accept, complete, do_flush;
    logic [LANES-1:0]       eff_mask;
    logic [PTR_W-1:0]       cur_ptr;

    function automatic logic [PTR_W-1:0] lowest_lane(input logic [LANES-1:0] m);
        lowest_lane = '0;
        for (int i = LANES - 1; i >= 0; i--)
            if (m[i]) lowest_lane = PTR_W'(i);
    endfunction

    function automatic logic [PTR_W-1:0] highest_lane(input logic [LANES-1:0] m);
        highest_lane = '0;
        for (int i = 0; i < LANES; i++)
            if (m[i]) highest_lane = PTR_W'(i);
    endfunction

    // Next enabled lane strictly above p, wrapping to the lowest enabled lane.
    function automatic logic [PTR_W-1:0] next_lane(input logic [LANES-1:0] m,
                                                   input logic [PTR_W-1:0] p);
        next_lane = lowest_lane(m);
        for (int i = LANES - 1; i >= 0; i--)
            if (m[i] && (i > int'(p))) next_lane = PTR_W'(i);
    endfunction

    always_comb begin
        empty     = (fill_q == '0);
        eff_mask  = empty ? laneEN : en_q;
        cur_ptr   = empty ? lowest_lane(laneEN) : ptr_q;
        slot_free = !vld_q || outRDY;
        inRDY     = (|eff_mask) && slot_free;
        accept    = inVLD && inRDY;

        acc_new  = acc_q;
        fill_new = fill_q;
        if (accept) begin
            acc_new[int'(cur_ptr)*WIDTH +: WIDTH] = byteStripingIN;
            fill_new[cur_ptr]                     = 1'b1;
        end

        complete = accept && (cur_ptr == highest_lane(eff_mask));
        // A completing symbol makes flush redundant; both paths emit the same way.
        do_flush = flush && slot_free && (fill_new != '0);

        acc_d  = acc_new;
        fill_d = fill_new;
        en_d   = (accept && empty) ? laneEN : en_q;
        ptr_d  = accept ? next_lane(eff_mask, cur_ptr) : ptr_q;
        out_d  = out_q;
        lvld_d = lvld_q;
        vld_d  = vld_q;

        if (complete || do_flush) begin
            for (int i = 0; i < LANES; i++)
                out_d[i*WIDTH +: WIDTH] = fill_new[i] ? acc_new[i*WIDTH +: WIDTH] : PAD;
            lvld_d = fill_new;
            vld_d  = 1'b1;
            acc_d  = '0;
            fill_d = '0;
            ptr_d  = '0;
        end else if (vld_q && outRDY) begin
            vld_d  = 1'b0;
            lvld_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            acc_q  <= '0;
            fill_q <= '0;
            en_q   <= '0;
            ptr_q  <= '0;
            out_q  <= '0;
            lvld_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            fill_q <= fill_d;
            en_q   <= en_d;
            ptr_q  <= ptr_d;
            out_q  <= out_d;
            lvld_q <= lvld_d;
            vld_q  <= vld_d;
        end
    end

    assign stripedOUT      = out_q;
    assign laneVLD         = lvld_q;
    assign byteStripingVLD = vld_q;
    assign lanePtr         = cur_ptr;

endmodule
